mem_port_arbiter: RTL and testbench

Sequences and shares the single unified instruction/data memory of the multicycle CPU between two requesters: the instruction-fetch path and the load/store path driven by `Controlador`. It owns the `IorD` address-mux select, `MemWrite`, and the capture strobes for the instruction register and the memory-data register. It hides the memory's fixed read latency behind a level-request / pulse-acknowledge handshake.

---
 rtl/cpu_ctrl_pkg.sv | 18 +
 rtl/mem_lat_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: arbiter state
// encoding, IorD address-mux codes and the legal memory latency range.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdWait = 3'd1,
    StRdCap  = 3'd2,
    StWr     = 3'd3
  } arb_state_e;

  localparam logic [2:0] IORD_PC     = 3'b000;
  localparam logic [2:0] IORD_ALUOUT = 3'b001;

  localparam int unsigned MemLatMin = 1;
  localparam int unsigned MemLatMax = 7;

endpackage

// File: rtl/mem_lat_counter.sv
// 3-bit loadable down-counter that times the memory read latency.
module mem_lat_counter
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [2:0] r_cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 3'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Zero flag straight from the register.
  always_comb begin
    o_zero = (r_cnt == 3'd0);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified instruction/data memory between the fetch path and the
// load/store path. Round-robin arbitration in IDLE, fixed read latency hidden
// behind a level-request / pulse-acknowledge handshake. All outputs are Moore.
module mem_port_arbiter
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req,
  input  logic       d_req,
  input  logic       d_we,
  output logic [2:0] IorD,
  output logic       MemWrite,
  output logic       Load_IR,
  output logic       Load_MDR,
  output logic       if_ack,
  output logic       d_ack,
  output logic       busy,
  output logic [2:0] state
);

  generate
    if ((MEM_LAT < MemLatMin) || (MEM_LAT > MemLatMax)) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT out of range 1..7");
    end
  endgenerate

  localparam logic [2:0] LatLoad = 3'(MEM_LAT - 1);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       r_gnt_data;   // granted requester of the current transaction
  logic       r_last_data;  // last grant went to data; resets to data so fetch wins first tie
  logic       w_grant;
  logic       w_grant_data;
  logic       w_cnt_zero;
  logic [2:0] w_sel;

  mem_lat_counter u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_grant),
    .i_load_val (LatLoad),
    .i_dec      (r_state == StRdWait),
    .o_zero     (w_cnt_zero)
  );

  // Next-state and arbitration decision.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_data = (if_req && d_req) ? ~r_last_data : d_req;
    unique case (r_state)
      StIdle: begin
        if (if_req || d_req) begin
          w_grant      = 1'b1;
          w_state_next = (w_grant_data && d_we) ? StWr : StRdWait;
        end
      end
      StRdWait: begin
        if (w_cnt_zero) begin
          w_state_next = StRdCap;
        end
      end
      StRdCap:  w_state_next = StIdle;
      StWr:     w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // State register plus grant bookkeeping captured on the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_gnt_data  <= 1'b0;
      r_last_data <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_gnt_data  <= w_grant_data;
        r_last_data <= w_grant_data;
      end
    end
  end

  // Moore output decode; reset forces IDLE so every output drops at once.
  always_comb begin
    w_sel    = r_gnt_data ? IORD_ALUOUT : IORD_PC;
    IorD     = IORD_PC;
    MemWrite = 1'b0;
    Load_IR  = 1'b0;
    Load_MDR = 1'b0;
    if_ack   = 1'b0;
    d_ack    = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      StIdle: begin
      end
      StRdWait: begin
        IorD = w_sel;
        busy = 1'b1;
      end
      StRdCap: begin
        IorD = w_sel;
        busy = 1'b1;
        if (r_gnt_data) begin
          Load_MDR = 1'b1;
          d_ack    = 1'b1;
        end else begin
          Load_IR = 1'b1;
          if_ack  = 1'b1;
        end
      end
      StWr: begin
        IorD     = w_sel;
        busy     = 1'b1;
        MemWrite = 1'b1;
        d_ack    = 1'b1;
      end
      default: begin
      end
    endcase
    state = r_state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed MEM_LAT=1 checks on one instance, randomized
// requesters against a transaction-countdown model on a MEM_LAT=3 instance.
module tb_mem_port_arbiter;

  localparam int unsigned Lat = 3;

  logic clk = 1'b0;
  logic reset;
  logic if_req, d_req, d_we;
  logic [2:0] IorD, state;
  logic MemWrite, Load_IR, Load_MDR, if_ack, d_ack, busy;

  logic if1, d1, we1;
  logic [2:0] IorD1, state1;
  logic MemWrite1, Load_IR1, Load_MDR1, if_ack1, d_ack1, busy1;

  int n_vec = 0;
  int n_err = 0;

  // Model: remaining busy cycles of the current transaction (0 = idle).
  int m_rem;
  bit m_data, m_we, m_last_data;
  logic e_if_ack, e_d_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(Lat)) u_dut (
    .clk(clk), .reset(reset), .if_req(if_req), .d_req(d_req), .d_we(d_we),
    .IorD(IorD), .MemWrite(MemWrite), .Load_IR(Load_IR), .Load_MDR(Load_MDR),
    .if_ack(if_ack), .d_ack(d_ack), .busy(busy), .state(state)
  );

  mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .if_req(if1), .d_req(d1), .d_we(we1),
    .IorD(IorD1), .MemWrite(MemWrite1), .Load_IR(Load_IR1), .Load_MDR(Load_MDR1),
    .if_ack(if_ack1), .d_ack(d_ack1), .busy(busy1), .state(state1)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit s_if, input bit s_d, input bit s_we);
    if (m_rem == 0) begin
      if (s_if || s_d) begin
        m_data      = (s_if && s_d) ? !m_last_data : s_d;
        m_last_data = m_data;
        m_we        = m_data && s_we;
        m_rem       = m_we ? 1 : Lat + 1;
      end
    end else begin
      m_rem--;
    end
  endtask

  task automatic check_main();
    bit b, fin;
    logic [2:0] e_state;
    b   = (m_rem != 0);
    fin = (m_rem == 1);
    e_if_ack = fin && !m_data;
    e_d_ack  = fin && m_data;
    e_state  = !b ? 3'd0 : m_we ? 3'd3 : fin ? 3'd2 : 3'd1;
    chk3("IorD",     IorD,     (b && m_data) ? 3'b001 : 3'b000);
    chk1("MemWrite", MemWrite, b && m_we);
    chk1("Load_IR",  Load_IR,  e_if_ack);
    chk1("Load_MDR", Load_MDR, fin && m_data && !m_we);
    chk1("if_ack",   if_ack,   e_if_ack);
    chk1("d_ack",    d_ack,    e_d_ack);
    chk1("busy",     busy,     b);
    chk3("state",    state,    e_state);
  endtask

  task automatic chk_zero_main(input string tag);
    chk3({tag, "_IorD"}, IorD, 3'b000);
    chk1({tag, "_MemWrite"}, MemWrite, 1'b0);
    chk1({tag, "_Load_IR"}, Load_IR, 1'b0);
    chk1({tag, "_Load_MDR"}, Load_MDR, 1'b0);
    chk1({tag, "_if_ack"}, if_ack, 1'b0);
    chk1({tag, "_d_ack"}, d_ack, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk3({tag, "_state"}, state, 3'b000);
  endtask

  // One clock: model sees the pre-edge inputs, outputs checked 1 ns later.
  task automatic step();
    bit s_if, s_d, s_we;
    @(posedge clk);
    s_if = if_req;
    s_d  = d_req;
    s_we = d_we;
    if (!reset) model_edge(s_if, s_d, s_we);
    #1;
    check_main();
  endtask

  initial begin
    int n_ifa, n_da, diff;
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if1 = 1'b0; d1 = 1'b0; we1 = 1'b0;
    m_rem = 0; m_data = 1'b0; m_we = 1'b0; m_last_data = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_main("reset");
    chk1("reset_busy1", busy1, 1'b0);
    chk3("reset_state1", state1, 3'd0);
    reset = 1'b0;

    // MEM_LAT=1 fetch: two busy cycles, capture in the second.
    if1 = 1'b1;
    step();
    chk3("l1_f_c1_IorD", IorD1, 3'b000);
    chk1("l1_f_c1_busy", busy1, 1'b1);
    chk1("l1_f_c1_Load_IR", Load_IR1, 1'b0);
    chk1("l1_f_c1_if_ack", if_ack1, 1'b0);
    step();
    chk3("l1_f_c2_IorD", IorD1, 3'b000);
    chk1("l1_f_c2_Load_IR", Load_IR1, 1'b1);
    chk1("l1_f_c2_if_ack", if_ack1, 1'b1);
    chk1("l1_f_c2_busy", busy1, 1'b1);
    if1 = 1'b0;
    step();
    chk1("l1_f_c3_busy", busy1, 1'b0);
    chk1("l1_f_c3_if_ack", if_ack1, 1'b0);

    // MEM_LAT=1 store: one cycle, d_we toggled after grant.
    d1 = 1'b1; we1 = 1'b1;
    step();
    chk1("l1_w_MemWrite", MemWrite1, 1'b1);
    chk1("l1_w_d_ack", d_ack1, 1'b1);
    chk3("l1_w_IorD", IorD1, 3'b001);
    chk3("l1_w_state", state1, 3'd3);
    d1 = 1'b0; we1 = 1'b0;
    step();
    chk1("l1_w_after_busy", busy1, 1'b0);
    chk1("l1_w_after_MemWrite", MemWrite1, 1'b0);

    // Randomized requesters on the MEM_LAT=3 instance; d_we churns every cycle.
    for (int i = 0; i < 400; i++) begin
      step();
      if (if_req && e_if_ack) if_req = ($urandom_range(0, 3) == 0);
      else if (!if_req)       if_req = 1'($urandom_range(0, 1));
      if (d_req && e_d_ack)   d_req = ($urandom_range(0, 3) == 0);
      else if (!d_req)        d_req = 1'($urandom_range(0, 1));
      d_we = 1'($urandom_range(0, 1));
    end

    // Drain to idle.
    for (int i = 0; i < 20; i++) begin
      if (m_rem == 0 && !if_req && !d_req) break;
      step();
      if (e_if_ack) if_req = 1'b0;
      if (e_d_ack)  d_req = 1'b0;
    end
    step();

    // Async reset in the middle of a read: outputs drop before any edge.
    if_req = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    chk_zero_main("midrd");
    m_rem = 0; m_data = 1'b0; m_we = 1'b0; m_last_data = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (e_if_ack) if_req = 1'b0;
    end

    // Both requesters held continuously: grants must alternate.
    n_ifa = 0; n_da = 0;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d_we = 1'($urandom_range(0, 1));
      step();
      if (if_ack) n_ifa++;
      if (d_ack)  n_da++;
    end
    diff = n_ifa - n_da;
    n_vec++;
    assert ((diff >= -1) && (diff <= 1) && (n_ifa > 0) && (n_da > 0)) else begin
      n_err++;
      $error("FAIL alternate: if_acks %0d d_acks %0d, required balanced within 1",
             n_ifa, n_da);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
